window_gen_h_uint12: RTL and testbench

Horizontal 1x5 window generator that turns a raster-order uint12 pixel stream into 5-tap windows with replicate border handling, one window per input pixel. It sits directly upstream of the horizontal Burt (1-4-6-4-1) filter stage and drives its `window_i`/`col_i`/`row_i`/`valid_i` inputs. It generates the two right-border windows at each row end by stalling the source for two cycles.

---
 rtl/window_gen_h_uint12_pkg.sv | 18 +
 rtl/window_gen_h_uint12_if.sv | 24 ++
 rtl/window_gen_h_uint12.sv | 117 +++++++++++
 tb/tb_window_gen_h_uint12.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/window_gen_h_uint12_pkg.sv
// Shared stream types for the pyramid front end: pixel/coordinate widths
// and the horizontal window generator state encoding.
package dfdd_stream_pkg;
  localparam int PIXEL_W = 12;
  localparam int COORD_W = 16;
  localparam int H_TAPS  = 5;

  typedef logic [PIXEL_W-1:0]       pixel_t;
  typedef logic [COORD_W-1:0]       coord_t;
  typedef pixel_t [H_TAPS-1:0]      window_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH1,
    ST_FLUSH2
  } win_state_t;
endpackage

// File: rtl/window_gen_h_uint12_if.sv
// Pixel-in / window-out bus of the horizontal window generator.
interface window_gen_h_uint12_if;
  import dfdd_stream_pkg::*;

  pixel_t         pixel_i;
  coord_t         col_i;
  coord_t         row_i;
  logic           valid_i;
  logic           ready_o;
  window_t [0:0]  window_o;
  coord_t         col_o;
  coord_t         row_o;
  logic           valid_o;

  modport slave (
    input  pixel_i, col_i, row_i, valid_i,
    output ready_o, window_o, col_o, row_o, valid_o
  );

  modport master (
    output pixel_i, col_i, row_i, valid_i,
    input  ready_o, window_o, col_o, row_o, valid_o
  );
endinterface

// File: rtl/window_gen_h_uint12.sv
// 1x5 horizontal window generator with replicate borders; the two right-edge
// windows of each row are produced while the source is stalled.
module window_gen_h_uint12
  import dfdd_stream_pkg::*;
#(
  parameter int IMAGE_WIDTH = 640
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  window_gen_h_uint12_if.slave  bus
);

  localparam coord_t LAST_COL = coord_t'(IMAGE_WIDTH - 1);

  win_state_t state_q, state_d;
  window_t    s_q, s_d;
  coord_t     row_q, row_d;
  coord_t     ctr_q, ctr_d;
  logic       valid_q, valid_d;
  window_t    win_q, win_d;
  coord_t     col_o_q, col_o_d;
  coord_t     row_o_q, row_o_d;

  logic       accept;
  logic       emit;
  pixel_t     shift_in;
  window_t    shifted;

  assign bus.ready_o     = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign bus.valid_o     = valid_q;
  assign bus.window_o[0] = win_q;
  assign bus.col_o       = col_o_q;
  assign bus.row_o       = row_o_q;

  assign accept   = bus.valid_i && bus.ready_o;
  // Flush states re-shift the newest entry to replicate the right edge.
  assign shift_in = (state_q == ST_RUN) ? bus.pixel_i : s_q[H_TAPS-1];
  assign shifted  = {shift_in, s_q[H_TAPS-1:1]};

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    row_d   = row_q;
    ctr_d   = ctr_q;
    valid_d = 1'b0;
    win_d   = win_q;
    col_o_d = col_o_q;
    row_o_d = row_o_q;
    emit    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept && bus.col_i == '0) begin
          s_d     = {H_TAPS{bus.pixel_i}};
          row_d   = bus.row_i;
          ctr_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (bus.col_i == '0) begin
            s_d   = {H_TAPS{bus.pixel_i}};
            row_d = bus.row_i;
            ctr_d = '0;
          end else begin
            s_d = shifted;
            if (bus.col_i >= coord_t'(2)) emit = 1'b1;
            if (bus.col_i == LAST_COL) state_d = ST_FLUSH1;
          end
        end
      end
      ST_FLUSH1: begin
        s_d     = shifted;
        emit    = 1'b1;
        state_d = ST_FLUSH2;
      end
      ST_FLUSH2: begin
        s_d     = shifted;
        emit    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (emit) begin
      valid_d = 1'b1;
      win_d   = shifted;
      col_o_d = ctr_q;
      row_o_d = row_q;
      ctr_d   = ctr_q + coord_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      row_q   <= '0;
      ctr_q   <= '0;
      valid_q <= 1'b0;
      win_q   <= '0;
      col_o_q <= '0;
      row_o_q <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      row_q   <= row_d;
      ctr_q   <= ctr_d;
      valid_q <= valid_d;
      win_q   <= win_d;
      col_o_q <= col_o_d;
      row_o_q <= row_o_d;
    end
  end

endmodule

// File: tb/tb_window_gen_h_uint12.sv
// Scoreboard bench: expected windows are queued from a clamp model as rows are
// issued; a monitor pops and compares on every valid_o.
module tb_window_gen_h_uint12;
  import dfdd_stream_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  window_gen_h_uint12_if if8();
  window_gen_h_uint12_if if3();

  window_gen_h_uint12 #(.IMAGE_WIDTH(8)) u8 (.clk_i(clk), .rst_i(rst_n), .bus(if8));
  window_gen_h_uint12 #(.IMAGE_WIDTH(3)) u3 (.clk_i(clk), .rst_i(rst_n), .bus(if3));

  typedef struct {
    window_t win;
    coord_t  col;
    coord_t  row;
  } exp_t;

  exp_t q8[$];
  exp_t q3[$];
  int errors = 0;
  int checks = 0;

  // Taps for centre c of a row whose pixel at column k is base+k.
  function automatic exp_t mk(input int w, input int base, input int c, input int row);
    exp_t e;
    for (int i = 0; i < H_TAPS; i++) begin
      int idx = c - 2 + i;
      if (idx < 0) idx = 0;
      if (idx > w - 1) idx = w - 1;
      e.win[i] = pixel_t'(base + idx);
    end
    e.col = coord_t'(c);
    e.row = coord_t'(row);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send8(input int pix, input int col, input int row, input int gap);
    bit ok;
    int n;
    if (gap > 0) begin
      if8.valid_i = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    if8.pixel_i = pixel_t'(pix);
    if8.col_i   = coord_t'(col);
    if8.row_i   = coord_t'(row);
    if8.valid_i = 1'b1;
    n = 0;
    do begin
      ok = if8.ready_o;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 20);
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: col %0d never accepted, got ready=0 expected 1", col);
    end
  endtask

  task automatic row8(input int base, input int row, input bit gaps, input bit chk_stall);
    for (int c = 0; c < 8; c++) q8.push_back(mk(8, base, c, row));
    for (int c = 0; c < 8; c++) begin
      send8(base + c, c, row, gaps ? int'($urandom_range(0, 2)) : 0);
      if (c == 7 && chk_stall) begin
        chk("ready_stall1", 64'(if8.ready_o), 64'(0));
        @(posedge clk); #1;
        chk("ready_stall2", 64'(if8.ready_o), 64'(0));
        @(posedge clk); #1;
        chk("ready_back", 64'(if8.ready_o), 64'(1));
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (if8.valid_o === 1'b1) begin
        checks++;
        if (q8.size() == 0) begin
          errors++;
          $display("FAIL w8_unexpected: got window col %0d row %0d expected no output",
                   if8.col_o, if8.row_o);
        end else begin
          e = q8.pop_front();
          if (if8.window_o[0] !== e.win || if8.col_o !== e.col || if8.row_o !== e.row) begin
            errors++;
            $display("FAIL w8_window: got %h c%0d r%0d expected %h c%0d r%0d",
                     if8.window_o[0], if8.col_o, if8.row_o, e.win, e.col, e.row);
          end
        end
      end
      if (if3.valid_o === 1'b1) begin
        checks++;
        if (q3.size() == 0) begin
          errors++;
          $display("FAIL w3_unexpected: got window col %0d expected no output", if3.col_o);
        end else begin
          e = q3.pop_front();
          if (if3.window_o[0] !== e.win || if3.col_o !== e.col || if3.row_o !== e.row) begin
            errors++;
            $display("FAIL w3_window: got %h c%0d r%0d expected %h c%0d r%0d",
                     if3.window_o[0], if3.col_o, if3.row_o, e.win, e.col, e.row);
          end
        end
      end
    end
  endtask

  initial begin
    if8.pixel_i = '0; if8.col_i = '0; if8.row_i = '0; if8.valid_i = 1'b0;
    if3.pixel_i = '0; if3.col_i = '0; if3.row_i = '0; if3.valid_i = 1'b0;

    #2;
    chk("rst_ready",  64'(if8.ready_o),     64'(1));
    chk("rst_valid",  64'(if8.valid_o),     64'(0));
    chk("rst_window", 64'(if8.window_o[0]), 64'(0));
    chk("rst_col",    64'(if8.col_o),       64'(0));
    chk("rst_row",    64'(if8.row_o),       64'(0));
    chk("rst_valid3", 64'(if3.valid_o),     64'(0));
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    fork monitor(); join_none

    // Row 3 then row 4 back to back at full rate.
    row8(100, 3, 1'b0, 1'b1);
    row8(200, 4, 1'b0, 1'b0);
    if8.valid_i = 1'b0;
    repeat (4) @(posedge clk); #1;

    // Random source gaps on the same data shape.
    row8(100, 5, 1'b1, 1'b0);
    if8.valid_i = 1'b0;
    repeat (4) @(posedge clk); #1;

    // Reset after col 4: centres 0..2 only, nothing pending afterwards.
    for (int c = 0; c < 3; c++) q8.push_back(mk(8, 400, c, 6));
    for (int c = 0; c < 5; c++) send8(400 + c, c, 6, 0);
    if8.valid_i = 1'b0;
    #6;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid",  64'(if8.valid_o),     64'(0));
    chk("midrst_window", 64'(if8.window_o[0]), 64'(0));
    chk("midrst_col",    64'(if8.col_o),       64'(0));
    @(posedge clk); #1;
    chk("midrst_ready",  64'(if8.ready_o),     64'(1));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Tail of the interrupted row is dropped; the next row is normal.
    for (int c = 5; c < 8; c++) send8(400 + c, c, 6, 0);
    if8.valid_i = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("drop_no_pending", 64'(q8.size()), 64'(0));
    row8(500, 7, 1'b0, 1'b0);
    if8.valid_i = 1'b0;

    // Minimum width.
    for (int c = 0; c < 3; c++) q3.push_back(mk(3, 7, c, 2));
    for (int c = 0; c < 3; c++) begin
      chk("w3_ready", 64'(if3.ready_o), 64'(1));
      if3.pixel_i = pixel_t'(7 + c);
      if3.col_i   = coord_t'(c);
      if3.row_i   = coord_t'(2);
      if3.valid_i = 1'b1;
      @(posedge clk); #1;
    end
    if3.valid_i = 1'b0;

    repeat (8) @(posedge clk); #1;
    chk("w8_drained", 64'(q8.size()), 64'(0));
    chk("w3_drained", 64'(q3.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
